cg_stage_seq: RTL and testbench
===============================

Name: cg_stage_seq

Overview:
- Parametrised N-stage successor to cg_core: a single trigger fires a chain of coil stages, each with its own pre-fire delay and on-time limit.
- Each stage's on-time ends early when that stage's gate sensor detects the projectile.
- Sits between the trigger/sensor front end and the per-coil drivers.
- Reports the active stage, per-stage timeout flags and the measured on-time of the most recent stage.

Parameters:
N_STAGES, 4, number of coil stages (1..16)
CNT_W, 24, width of delay, limit and accumulator counters
STG_W, 4, width of O_STG; must satisfy 2**STG_W >= N_STAGES

Ports:
clk  in  1  system clock; all logic on rising edge
I_RST  in  1  synchronous active-high reset
I_TRIG  in  1  fire request, level; rising edge starts a sequence
I_GATE  in  N_STAGES  per-stage projectile sensor, active-high, synchronous to clk
I_DLY  in  N_STAGES*CNT_W  packed per-stage pre-fire delay in cycles; stage k at bits [k*CNT_W +: CNT_W]
I_LMT  in  N_STAGES*CNT_W  packed per-stage on-time limit in cycles
I_EN  in  1  arm; rising I_TRIG is ignored while low
I_OE  in  1  output enable; gates O_SOE only
I_LEN  in  1  limit enable; when low, limit = all-ones
O_SOE  out  N_STAGES  one-hot coil drive
O_RTE  out  1  ready-to-engage: IDLE and I_EN high
O_STG  out  STG_W  index of current/last stage
O_ACC  out  CNT_W  on-time of current/last stage
O_TMO  out  N_STAGES  sticky per-stage timeout flags
O_DONE  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset: state IDLE; all counters 0; O_SOE=0, O_STG=0, O_ACC=0, O_TMO=0, O_DONE=0. O_RTE=I_EN (combinational from state). Reset mid-sequence drops O_SOE on the same edge.
- I_TRIG rising edge: registered previous-value detector. Edge is seen at cycle T when I_TRIG=1 and the previous sample was 0.
- IDLE: on edge with I_EN=1 -> DELAY at T+1; O_STG=0, O_TMO cleared, O_ACC cleared. Edge with I_EN=0 is discarded and not remembered.
- DELAY(k): held for exactly dly[k] cycles.
  - dly[k]=0: the transition into DELAY goes directly to FIRE.
  - For stage 0 with dly=0, O_SOE[0] is first high at T+1.
- FIRE(k): internal soe[k]=1; O_ACC increments each cycle starting at 1 on the first FIRE cycle.
  - Ends after the cycle in which I_GATE[k]=1 or O_ACC==lmt_eff, whichever comes first.
  - Gate already high on entry: exactly 1 cycle of drive, O_ACC=1.
  - lmt_eff = (I_LEN ? lmt[k] : all-ones); lmt_eff=0 is treated as 1.
  - Limit reached with gate low: O_TMO[k] set. Gate and limit on the same cycle counts as gate (no TMO).
- After FIRE(k): if k<N_STAGES-1 -> DELAY(k+1), O_STG=k+1, O_ACC cleared on entry to FIRE(k+1). Otherwise -> DONE with O_DONE pulsed for 1 cycle.
- DONE: wait for I_TRIG=0, then IDLE. Retriggers are never accepted during a sequence.
- I_DLY/I_LMT: sampled per stage on entry to that stage's DELAY; later changes do not affect the running stage.
- I_EN low mid-sequence: aborts to IDLE next edge, O_SOE=0, no O_DONE.
- O_SOE = soe & {N{I_OE}}, registered, zero-latency relative to state. I_OE low does not stop sequencing or counting.
- At most one O_SOE bit high in any cycle. No overlap between stages, and no gap other than dly.
- Counters never wrap: O_ACC saturates at lmt_eff by construction.

Optional Feature:
- Macro: CG_SEQ_TMO_ABORT_EN.
- Defined: a timeout in any stage sets O_TMO[k], skips all remaining stages and goes to DONE with O_DONE pulsed. O_STG holds the faulting stage.
- Undefined: a timeout only sets the flag and the sequence continues to the next stage.

Test Plan:
- N=4, all dly=2, lmt=10, I_LEN=1, gates never high, I_TRIG 0->1:
  - Without macro: each O_SOE[k] high exactly 10 cycles, 2-cycle gaps; O_TMO=4'b1111; O_DONE pulse once; O_ACC=10.
  - With CG_SEQ_TMO_ABORT_EN: only O_SOE[0] fires; O_STG=0; O_TMO=4'b0001.
- dly={0,3,0,5}, lmt=200, I_GATE[k] pulsed 7 cycles after each SOE[k] rises -> each SOE high 8 cycles, O_ACC=8, O_TMO=0, O_SOE[0] high at T+1.
- I_LEN=0, lmt=5, gate at on-cycle 40 -> SOE held 40 cycles, no TMO.
- I_OE=0 for whole sequence -> O_SOE stays 0; O_STG/O_ACC/O_DONE behave identically to the I_OE=1 run.
- I_RST=1 during FIRE(1) -> O_SOE=0 next edge, all outputs at reset values.
- Retrigger: I_TRIG toggled during a sequence -> ignored. I_TRIG held high after DONE -> no refire until it goes low, then a new rising edge starts a fresh sequence.
- I_EN=0 with a rising trigger -> O_RTE=0, no firing.

Source files
------------

// File: rtl/cg_stage_seq.sv
// cg_stage_seq - N-stage coil sequencer.
// A rising trigger fires each stage in turn: a per-stage pre-fire delay,
// then a drive window that ends on that stage's gate sensor or on its
// on-time limit. Reports active stage, sticky timeout flags, last on-time
// and a one-cycle completion pulse.
// Optional build macro: CG_SEQ_TMO_ABORT_EN - a timeout in any stage skips
// the remaining stages and completes the sequence immediately.
module cg_stage_seq #(
   parameter int N_STAGES = 4,
   parameter int CNT_W    = 24,
   parameter int STG_W    = 4
) (
   input  logic                      clk,
   input  logic                      I_RST,
   input  logic                      I_TRIG,
   input  logic [N_STAGES-1:0]       I_GATE,
   input  logic [N_STAGES*CNT_W-1:0] I_DLY,
   input  logic [N_STAGES*CNT_W-1:0] I_LMT,
   input  logic                      I_EN,
   input  logic                      I_OE,
   input  logic                      I_LEN,
   output logic [N_STAGES-1:0]       O_SOE,
   output logic                      O_RTE,
   output logic [STG_W-1:0]          O_STG,
   output logic [CNT_W-1:0]          O_ACC,
   output logic [N_STAGES-1:0]       O_TMO,
   output logic                      O_DONE
);

`ifdef CG_SEQ_TMO_ABORT_EN
   localparam bit TMO_ABORT = 1'b1;
`else
   localparam bit TMO_ABORT = 1'b0;
`endif

   localparam logic [STG_W-1:0] LAST_IDX = STG_W'(N_STAGES - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_FIRE,
      S_DONE
   } state_t;

   state_t              state;
   logic                trig_prev;
   logic [CNT_W-1:0]    dly_rem;
   logic [CNT_W-1:0]    lmt_eff;

   logic [STG_W-1:0]    nxt_idx;
   logic [CNT_W-1:0]    nxt_dly;
   logic [CNT_W-1:0]    nxt_lmt;
   logic [CNT_W-1:0]    nxt_lmt_eff;
   logic [N_STAGES-1:0] nxt_hot;
   logic [N_STAGES-1:0] cur_hot;
   logic [N_STAGES-1:0] oe_mask;
   logic                trig_rise;
   logic                gate_hit;
   logic                at_limit;
   logic                last_stage;

   assign oe_mask    = {N_STAGES{I_OE}};
   assign trig_rise  = I_TRIG & ~trig_prev;
   assign gate_hit   = |(I_GATE & cur_hot);
   assign at_limit   = (O_ACC == lmt_eff);
   assign last_stage = (O_STG == LAST_IDX);
   assign O_RTE      = (state == S_IDLE) & I_EN;

   // Look up the stage about to be entered (stage 0 from IDLE, else the next
   // one) and decode the current stage into a one-hot coil mask.
   always_comb begin
      nxt_idx     = (state == S_IDLE) ? '0 : O_STG + STG_W'(1);
      nxt_dly     = '0;
      nxt_lmt     = '0;
      nxt_hot     = '0;
      cur_hot     = '0;
      for (int k = 0; k < N_STAGES; k++) begin
         if (nxt_idx == STG_W'(k)) begin
            nxt_dly    = I_DLY[k*CNT_W +: CNT_W];
            nxt_lmt    = I_LMT[k*CNT_W +: CNT_W];
            nxt_hot[k] = 1'b1;
         end
         if (O_STG == STG_W'(k)) begin
            cur_hot[k] = 1'b1;
         end
      end
      if (!I_LEN) begin
         nxt_lmt_eff = '1;
      end else if (nxt_lmt == '0) begin
         nxt_lmt_eff = ONE;
      end else begin
         nxt_lmt_eff = nxt_lmt;
      end
   end

   // Sequencer: one state machine that owns every registered output so coil
   // drive changes on exactly the same edge as the state it belongs to.
   always_ff @(posedge clk) begin
      if (I_RST) begin
         state     <= S_IDLE;
         trig_prev <= 1'b0;
         dly_rem   <= '0;
         lmt_eff   <= '0;
         O_SOE     <= '0;
         O_STG     <= '0;
         O_ACC     <= '0;
         O_TMO     <= '0;
         O_DONE    <= 1'b0;
      end else begin
         trig_prev <= I_TRIG;
         O_DONE    <= 1'b0;
         case (state)
            S_IDLE: begin
               O_SOE <= '0;
               if (trig_rise && I_EN) begin
                  O_STG   <= '0;
                  O_TMO   <= '0;
                  lmt_eff <= nxt_lmt_eff;
                  if (nxt_dly == '0) begin
                     state <= S_FIRE;
                     O_ACC <= ONE;
                     O_SOE <= nxt_hot & oe_mask;
                  end else begin
                     state   <= S_DELAY;
                     dly_rem <= nxt_dly;
                     O_ACC   <= '0;
                  end
               end
            end

            S_DELAY: begin
               if (!I_EN) begin
                  state <= S_IDLE;
                  O_SOE <= '0;
               end else if (dly_rem == ONE) begin
                  state <= S_FIRE;
                  O_ACC <= ONE;
                  O_SOE <= cur_hot & oe_mask;
               end else begin
                  dly_rem <= dly_rem - ONE;
                  O_SOE   <= '0;
               end
            end

            S_FIRE: begin
               if (!I_EN) begin
                  state <= S_IDLE;
                  O_SOE <= '0;
               end else if (gate_hit || at_limit) begin
                  if (!gate_hit) begin
                     O_TMO <= O_TMO | cur_hot;
                  end
                  if (last_stage || (TMO_ABORT && !gate_hit)) begin
                     state  <= S_DONE;
                     O_DONE <= 1'b1;
                     O_SOE  <= '0;
                  end else begin
                     O_STG   <= nxt_idx;
                     lmt_eff <= nxt_lmt_eff;
                     if (nxt_dly == '0) begin
                        state <= S_FIRE;
                        O_ACC <= ONE;
                        O_SOE <= nxt_hot & oe_mask;
                     end else begin
                        state   <= S_DELAY;
                        dly_rem <= nxt_dly;
                        O_SOE   <= '0;
                     end
                  end
               end else begin
                  O_ACC <= O_ACC + ONE;
                  O_SOE <= cur_hot & oe_mask;
               end
            end

            S_DONE: begin
               O_SOE <= '0;
               if (!I_TRIG) begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
               O_SOE <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cg_stage_seq.sv
// tb_cg_stage_seq - directed bench for cg_stage_seq with a schedule-based
// reference model. Honours CG_SEQ_TMO_ABORT_EN when it is defined.
module tb_cg_stage_seq;
   localparam int N    = 4;
   localparam int W    = 24;
   localparam int SW   = 4;
   localparam int MAXR = 320;
`ifdef CG_SEQ_TMO_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           I_RST;
   logic           I_TRIG;
   logic [N-1:0]   I_GATE;
   logic [N*W-1:0] I_DLY;
   logic [N*W-1:0] I_LMT;
   logic           I_EN;
   logic           I_OE;
   logic           I_LEN;
   logic [N-1:0]   O_SOE;
   logic           O_RTE;
   logic [SW-1:0]  O_STG;
   logic [W-1:0]   O_ACC;
   logic [N-1:0]   O_TMO;
   logic           O_DONE;

   cg_stage_seq #(.N_STAGES(N), .CNT_W(W), .STG_W(SW)) dut (
      .clk(clk), .I_RST(I_RST), .I_TRIG(I_TRIG), .I_GATE(I_GATE),
      .I_DLY(I_DLY), .I_LMT(I_LMT), .I_EN(I_EN), .I_OE(I_OE), .I_LEN(I_LEN),
      .O_SOE(O_SOE), .O_RTE(O_RTE), .O_STG(O_STG), .O_ACC(O_ACC),
      .O_TMO(O_TMO), .O_DONE(O_DONE)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int errors;
   int checks;
   int cyc;
   int t0;
   int chkLim;
   bit seqOn;

   int cfgDly[N];
   int cfgLmt[N];
   int cfgGate[N];
   bit cfgLen;
   bit cfgOe;

   int stStart[N];
   int stEnd[N];
   int stLen[N];
   bit stTmo[N];
   int gateOff[N];
   int nFired;
   int doneOff;

   logic [N-1:0] expSoe[MAXR];
   int           expStg[MAXR];
   longint       expAcc[MAXR];
   logic [N-1:0] expTmo[MAXR];
   bit           expDone[MAXR];

   int soeHi[N];
   int baseHi[N];
   int doneCnt;
   int baseDone;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc - t0, act, exp);
      end
   endtask

   // Reference model: lay out each stage's drive window on a timeline
   // (offsets from the trigger cycle), then derive every output from it.
   task automatic buildModel();
      int     prevEnd;
      longint eff;
      prevEnd = 0;
      nFired  = 0;
      for (int k = 0; k < N; k++) begin
         stStart[k] = -1; stEnd[k] = -1; stLen[k] = 0; stTmo[k] = 0; gateOff[k] = -1;
      end
      for (int k = 0; k < N; k++) begin
         if (cfgLen) eff = (cfgLmt[k] == 0) ? 1 : cfgLmt[k];
         else        eff = (longint'(1) << W) - 1;
         stStart[k] = prevEnd + 1 + cfgDly[k];
         if (cfgGate[k] != 0 && cfgGate[k] <= eff) begin
            stLen[k]   = cfgGate[k];
            gateOff[k] = stStart[k] + cfgGate[k] - 1;
         end else begin
            stLen[k] = int'(eff);
            stTmo[k] = 1'b1;
         end
         stEnd[k] = stStart[k] + stLen[k] - 1;
         prevEnd  = stEnd[k];
         nFired   = k + 1;
         if (ABORT && stTmo[k]) break;
      end
      doneOff = prevEnd + 1;
      for (int r = 0; r < MAXR; r++) begin
         expSoe[r]  = '0;
         expStg[r]  = 0;
         expAcc[r]  = 0;
         expTmo[r]  = '0;
         expDone[r] = (r == doneOff);
         for (int j = 0; j < nFired; j++) begin
            if (j < nFired - 1 && r > stEnd[j]) expStg[r] = j + 1;
            if (r >= stStart[j]) expAcc[r] = (r <= stEnd[j]) ? r - stStart[j] + 1 : stLen[j];
            if (cfgOe && r >= stStart[j] && r <= stEnd[j]) expSoe[r][j] = 1'b1;
            if (stTmo[j] && r > stEnd[j]) expTmo[r][j] = 1'b1;
         end
      end
   endtask

   task automatic compareModel(input int r);
      checkOutput("soe",    O_SOE,  expSoe[r]);
      checkOutput("stg",    O_STG,  expStg[r]);
      checkOutput("acc",    O_ACC,  expAcc[r]);
      checkOutput("tmo",    O_TMO,  expTmo[r]);
      checkOutput("done",   O_DONE, expDone[r]);
      checkOutput("rte",    O_RTE,  0);
      checkOutput("onehot", $countones(O_SOE) <= 1, 1);
   endtask

   // One clock: drive gate pulses after the edge, compare on the falling edge.
   task automatic tick();
      int r;
      @(posedge clk);
      cyc++;
      #1;
      r = cyc - t0;
      for (int k = 0; k < N; k++)
         I_GATE[k] = seqOn && (gateOff[k] >= 0) && (r == gateOff[k]);
      @(negedge clk);
      if (seqOn && r >= 1 && r <= doneOff && r <= chkLim && r < MAXR) compareModel(r);
      for (int k = 0; k < N; k++) if (O_SOE[k]) soeHi[k]++;
      if (O_DONE) doneCnt++;
   endtask

   task automatic snapBase();
      for (int k = 0; k < N; k++) baseHi[k] = soeHi[k];
      baseDone = doneCnt;
   endtask

   function automatic int soeTotal();
      int s;
      s = 0;
      for (int k = 0; k < N; k++) s += soeHi[k] - baseHi[k];
      return s;
   endfunction

   task automatic setUniform(input int d, input int l, input int g, input bit len, input bit oe);
      for (int k = 0; k < N; k++) begin
         cfgDly[k] = d; cfgLmt[k] = l; cfgGate[k] = g;
      end
      cfgLen = len;
      cfgOe  = oe;
   endtask

   task automatic setB();
      setUniform(0, 200, 8, 1'b1, 1'b1);
      cfgDly[1] = 3;
      cfgDly[3] = 5;
   endtask

   // Launch a sequence from the current config: stop>0 runs that many
   // cycles, otherwise runs to the model's completion plus 'extra'.
   task automatic applyStimulus(input int stop, input int extra, input bit hold, input bit toggle);
      int run;
      for (int k = 0; k < N; k++) begin
         I_DLY[k*W +: W] = W'(cfgDly[k]);
         I_LMT[k*W +: W] = W'(cfgLmt[k]);
      end
      I_LEN = cfgLen;
      I_OE  = cfgOe;
      buildModel();
      snapBase();
      run    = (stop > 0) ? stop : doneOff + extra;
      t0     = cyc;
      chkLim = MAXR;
      seqOn  = 1'b1;
      I_TRIG = 1'b1;
      for (int i = 0; i < run; i++) begin
         tick();
         if (!hold && cyc - t0 == 3) I_TRIG = 1'b0;
         if (toggle && cyc - t0 == 5) I_TRIG = 1'b0;
         if (toggle && cyc - t0 == 6) I_TRIG = 1'b1;
      end
   endtask

   // Run-away guard.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenario sequence.
   initial begin
      errors = 0; checks = 0; cyc = 0; t0 = 0; chkLim = 0; seqOn = 1'b0;
      doneOff = 0; doneCnt = 0; baseDone = 0;
      for (int k = 0; k < N; k++) begin
         gateOff[k] = -1; soeHi[k] = 0; baseHi[k] = 0;
      end
      I_RST = 1'b1; I_TRIG = 1'b0; I_GATE = '0; I_DLY = '0; I_LMT = '0;
      I_EN = 1'b1; I_OE = 1'b1; I_LEN = 1'b1;
      repeat (3) tick();
      I_RST = 1'b0;
      tick();

      $display("[TB] reset values");
      checkOutput("rst_soe",  O_SOE,  0);
      checkOutput("rst_stg",  O_STG,  0);
      checkOutput("rst_acc",  O_ACC,  0);
      checkOutput("rst_tmo",  O_TMO,  0);
      checkOutput("rst_done", O_DONE, 0);
      checkOutput("rst_rte",  O_RTE,  1);
      I_EN = 1'b0; #1;
      checkOutput("rte_en_low", O_RTE, 0);
      I_EN = 1'b1; #1;

      $display("[TB] all stages time out");
      setUniform(2, 10, 0, 1'b1, 1'b1);
      applyStimulus(0, 3, 1'b0, 1'b0);
      seqOn = 1'b0;
      checkOutput("a_done_off", doneOff, ABORT ? 13 : 49);
      checkOutput("a_tmo",   O_TMO, ABORT ? 4'b0001 : 4'b1111);
      checkOutput("a_acc",   O_ACC, 10);
      checkOutput("a_stg",   O_STG, ABORT ? 0 : 3);
      checkOutput("a_ndone", doneCnt - baseDone, 1);
      checkOutput("a_soe0",  soeHi[0] - baseHi[0], 10);
      checkOutput("a_soe3",  soeHi[3] - baseHi[3], ABORT ? 0 : 10);
      checkOutput("a_rte",   O_RTE, 1);

      $display("[TB] output enable low");
      setUniform(2, 10, 0, 1'b1, 1'b0);
      applyStimulus(0, 3, 1'b0, 1'b0);
      seqOn = 1'b0;
      checkOutput("d_soe_total", soeTotal(), 0);
      checkOutput("d_ndone", doneCnt - baseDone, 1);
      checkOutput("d_acc",   O_ACC, 10);
      I_OE = 1'b1;

      $display("[TB] gated stages");
      setB();
      applyStimulus(0, 3, 1'b0, 1'b0);
      seqOn = 1'b0;
      checkOutput("b_start0",   stStart[0], 1);
      checkOutput("b_done_off", doneOff, 41);
      checkOutput("b_acc",  O_ACC, 8);
      checkOutput("b_tmo",  O_TMO, 0);
      checkOutput("b_soe2", soeHi[2] - baseHi[2], 8);

      $display("[TB] limit disabled");
      setUniform(1, 5, 40, 1'b0, 1'b1);
      applyStimulus(0, 3, 1'b0, 1'b0);
      seqOn = 1'b0;
      checkOutput("c_done_off", doneOff, 165);
      checkOutput("c_acc",  O_ACC, 40);
      checkOutput("c_tmo",  O_TMO, 0);
      checkOutput("c_soe1", soeHi[1] - baseHi[1], 40);

      $display("[TB] retrigger and held trigger");
      setB();
      applyStimulus(0, 6, 1'b1, 1'b1);
      seqOn = 1'b0;
      checkOutput("t_rte_held", O_RTE, 0);
      checkOutput("t_ndone",    doneCnt - baseDone, 1);
      checkOutput("t_soe_idle", O_SOE, 0);
      I_TRIG = 1'b0;
      tick();
      tick();
      checkOutput("t_rte_rel", O_RTE, 1);
      applyStimulus(0, 3, 1'b0, 1'b0);
      seqOn = 1'b0;
      checkOutput("t2_ndone", doneCnt - baseDone, 1);
      checkOutput("t2_acc",   O_ACC, 8);

      $display("[TB] reset during stage 1");
      setB();
      applyStimulus(14, 0, 1'b0, 1'b0);
      checkOutput("r_fire1", O_SOE, 4'b0010);
      chkLim = 14;
      I_RST  = 1'b1;
      tick();
      checkOutput("r_soe",  O_SOE,  0);
      checkOutput("r_stg",  O_STG,  0);
      checkOutput("r_acc",  O_ACC,  0);
      checkOutput("r_tmo",  O_TMO,  0);
      checkOutput("r_done", O_DONE, 0);
      checkOutput("r_rte",  O_RTE,  1);
      I_RST = 1'b0;
      seqOn = 1'b0;
      tick();

      $display("[TB] arm dropped mid-sequence");
      setB();
      applyStimulus(15, 0, 1'b0, 1'b0);
      chkLim = 15;
      I_EN   = 1'b0;
      tick();
      checkOutput("e_soe", O_SOE, 0);
      checkOutput("e_rte", O_RTE, 0);
      repeat (40) tick();
      seqOn = 1'b0;
      checkOutput("e_ndone",   doneCnt - baseDone, 0);
      checkOutput("e_soe_end", O_SOE, 0);
      I_EN = 1'b1; #1;
      checkOutput("e_rte_idle", O_RTE, 1);

      $display("[TB] trigger while disarmed");
      I_EN = 1'b0;
      tick();
      snapBase();
      I_TRIG = 1'b1;
      tick();
      checkOutput("n_rte", O_RTE, 0);
      repeat (20) tick();
      I_EN = 1'b1;
      repeat (10) tick();
      checkOutput("n_soe_total", soeTotal(), 0);
      checkOutput("n_rte_armed", O_RTE, 1);
      I_TRIG = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
